diff_restore_unit: RTL and testbench

//  Receive end of the subtractor result stream. Each sample holds a 9-bit difference

---
 rtl/diff_restore_unit_if.sv | 35 +++
 rtl/diff_restore_unit.sv | 106 ++++++++++
 tb/tb_diff_restore_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/diff_restore_unit_if.sv
// Stream interface for the difference-restore unit: b/diff in, a_out/err out.
interface diff_restore_unit_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] b;
    logic [8:0] diff;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_out;
    logic       err;

    // Upstream/downstream view: drives the sample in and the output ready.
    modport master (
        output in_valid,
        output b,
        output diff,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  a_out,
        input  err
    );

    // Unit view.
    modport slave (
        input  in_valid,
        input  b,
        input  diff,
        input  out_ready,
        output in_ready,
        output out_valid,
        output a_out,
        output err
    );
endinterface

// File: rtl/diff_restore_unit.sv
// Rebuilds the minuend a = b + diff from a (b, diff) stream and flags diffs that no
// 8-bit minuend can produce. Two-stage valid/ready pipeline with saturating counters.
module diff_restore_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    diff_restore_unit_if.slave    bus,
    input  logic                  clr,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic             en;
    logic             out_xfer;
    logic [8:0]       sum9;

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_b_q, s1_b_d;
    logic [8:0]       s1_diff_q, s1_diff_d;

    logic             out_valid_q, out_valid_d;
    logic [7:0]       a_out_q, a_out_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Whole pipeline advances together whenever the output slot is free or being taken.
    always_comb begin
        en       = ~out_valid_q | bus.out_ready;
        out_xfer = out_valid_q & bus.out_ready;
    end

    // Stage next-state: S1 captures the input, S2 adds and splits carry into err.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_b_d      = s1_b_q;
        s1_diff_d   = s1_diff_q;
        out_valid_d = out_valid_q;
        a_out_d     = a_out_q;
        err_d       = err_q;
        // Bit 8 set means b + diff lands outside 0..255, i.e. no 8-bit a exists.
        sum9        = {1'b0, s1_b_q} + s1_diff_q;
        if (en) begin
            s1_valid_d  = bus.in_valid;
            out_valid_d = s1_valid_q;
            if (bus.in_valid) begin
                s1_b_d    = bus.b;
                s1_diff_d = bus.diff;
            end
            if (s1_valid_q) begin
                a_out_d = sum9[7:0];
                err_d   = sum9[8];
            end
        end
    end

    // Counter next-state: clear beats a same-cycle transfer; both saturate.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (clr) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
        end else if (out_xfer) begin
            if (sample_cnt_q != CntMax) begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
            end
            if (err_q && (err_cnt_q != CntMax)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; async reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_b_q       <= '0;
            s1_diff_q    <= '0;
            out_valid_q  <= 1'b0;
            a_out_q      <= '0;
            err_q        <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_b_q       <= s1_b_d;
            s1_diff_q    <= s1_diff_d;
            out_valid_q  <= out_valid_d;
            a_out_q      <= a_out_d;
            err_q        <= err_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.a_out     = a_out_q;
    assign bus.err       = err_q;
    assign sample_cnt    = sample_cnt_q;
    assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_diff_restore_unit.sv
// Directed bench for diff_restore_unit (CNT_W=4 so saturation is reachable).
module tb_diff_restore_unit;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] err_cnt;
    int            checks = 0;
    int            errors = 0;

    diff_restore_unit_if bus ();

    diff_restore_unit #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr        (clr),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; clr = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.b = '0; bus.diff = '0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.a_out !== 8'd0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_data: got a=%0d err=%b expected 0/0", bus.a_out, bus.err);
        end
        checks++;
        if (sample_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", sample_cnt, err_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.b = 8'd10; bus.diff = 9'd20; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_latency: got out_valid=%b expected 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 8'd30 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_out: got v=%b a=%0d err=%b expected 1/30/0",
                     bus.out_valid, bus.a_out, bus.err);
        end
        @(negedge clk);
        checks++;
        if (sample_cnt !== 4'd1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt: got cnt=%0d v=%b expected 1/0", sample_cnt, bus.out_valid);
        end
    endtask

    task automatic test_arith;
        logic [7:0] vb[4] = '{8'd200, 8'd200, 8'd0, 8'd255};
        logic [8:0] vd[4] = '{9'h1CE, 9'd100, 9'h100, 9'h101};
        logic [7:0] ea[4] = '{8'd150, 8'd44, 8'd0, 8'd0};
        logic       ee[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            if (i < 4) begin
                bus.in_valid = 1'b1; bus.b = vb[i]; bus.diff = vd[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.a_out !== ea[i-2] || bus.err !== ee[i-2]) begin
                    errors++;
                    $display("FAIL arith_%0d: got v=%b a=%0d err=%b expected 1/%0d/%b",
                             i - 2, bus.out_valid, bus.a_out, bus.err, ea[i-2], ee[i-2]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (sample_cnt !== 4'd4 || err_cnt !== 4'd2) begin
            errors++;
            $display("FAIL arith_cnt: got %0d/%0d expected 4/2", sample_cnt, err_cnt);
        end
    endtask

    task automatic test_stall;
        logic [7:0] vb[5] = '{8'd1, 8'd50, 8'd255, 8'd0, 8'd128};
        logic [8:0] vd[5] = '{9'd2, 9'h1F6, 9'd0, 9'h0FF, 9'h180};
        logic [7:0] ea[5] = '{8'd3, 8'd40, 8'd255, 8'd255, 8'd0};
        int         sent = 0;
        int         got  = 0;
        logic       held = 1'b0;
        logic [7:0] held_a = '0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c != 0) @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 5);
            if (sent < 5) begin
                bus.in_valid = 1'b1; bus.b = vb[sent]; bus.diff = vd[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.a_out !== held_a) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b a=%0d expected 1/%0d",
                             bus.out_valid, bus.a_out, held_a);
                end
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (got >= 5) begin
                    errors++; $display("FAIL stall_dup: got extra a=%0d expected none", bus.a_out);
                end else if (bus.a_out !== ea[got]) begin
                    errors++;
                    $display("FAIL stall_order_%0d: got a=%0d expected %0d", got, bus.a_out, ea[got]);
                end
                got++;
            end
            held   = (bus.out_valid === 1'b1) && !bus.out_ready;
            held_a = bus.a_out;
            if (bus.in_valid && bus.in_ready === 1'b1) sent++;
            if (sent == 5 && got >= 5) break;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 5) begin
            errors++; $display("FAIL stall_count: got %0d samples expected 5", got);
        end
        @(negedge clk);
        checks++;
        if (sample_cnt !== 4'd5 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_cnt: got cnt=%0d v=%b expected 5/0", sample_cnt, bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.b = 8'd3; bus.diff = 9'd4;
        @(negedge clk);
        bus.b = 8'd5; bus.diff = 9'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 8'd7) begin
            errors++;
            $display("FAIL midrst_pre: got v=%b a=%0d expected 1/7", bus.out_valid, bus.a_out);
        end
        #1; rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.a_out !== 8'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out: got v=%b a=%0d err=%b expected 0/0/0",
                     bus.out_valid, bus.a_out, bus.err);
        end
        checks++;
        if (sample_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++; $display("FAIL midrst_cnt: got %0d/%0d expected 0/0", sample_cnt, err_cnt);
        end
        @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || sample_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midrst_drop: got v=%b cnt=%0d expected 0/0", bus.out_valid, sample_cnt);
        end
    endtask

    task automatic test_saturate;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            bus.in_valid = (c < 20); bus.b = 8'd0; bus.diff = 9'h100;
        end
        @(negedge clk);
        checks++;
        if (sample_cnt !== 4'd15 || err_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_cnt: got %0d/%0d expected 15/15", sample_cnt, err_cnt);
        end
        bus.in_valid = 1'b1; bus.b = 8'd7; bus.diff = 9'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 8'd8 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL sat_out: got v=%b a=%0d err=%b expected 1/8/0",
                     bus.out_valid, bus.a_out, bus.err);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (sample_cnt !== 4'd0 || err_cnt !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_xfer: got %0d/%0d v=%b expected 0/0/0",
                     sample_cnt, err_cnt, bus.out_valid);
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] exp_q[$];
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] e;
        int         got = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 65540; c++) begin
            @(negedge clk);
            if (c < 65536) begin
                av = c[15:8]; bv = c[7:0];
                bus.in_valid = 1'b1; bus.b = bv; bus.diff = {1'b0, av} - {1'b0, bv};
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL exh_spurious: got a=%0d expected no output", bus.a_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.a_out !== e || bus.err !== 1'b0) begin
                        errors++;
                        $display("FAIL exh_%0d: got a=%0d err=%b expected %0d/0",
                                 got, bus.a_out, bus.err, e);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) exp_q.push_back(av);
        end
        checks++;
        if (got != 65536 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL exh_count: got %0d outputs, %0d pending expected 65536/0",
                     got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_stall();
        test_reset_midstream();
        test_saturate();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
